// File: rtl/eng_ucq_port.sv
// Engine-side end of the unit-clause arbiter link.
// UCQ_IN buffers literals implied by the local BCP engine and presents its head
// to the arbiter; UCQ_OUT buffers literals broadcast by the arbiter and drains
// them into the local engine. Both queues are independent strict FIFOs.
//
// Handshake: a push is taken on a clock edge when its enable is high, the
// literal is non-zero and the queue is not full (or a pop of the same queue
// takes effect in that cycle). A pop is taken when its enable is high and the
// queue is non-empty; the head output is meaningful only while valid is high.

module eng_ucq_fifo #(
  parameter int DEPTH = 8,
  parameter int LIT_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [LIT_W-1:0]           lit,
  input  logic                       pop,
  output logic [LIT_W-1:0]           head,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [LIT_W-1:0] mem [DEPTH];
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_ptr;
  logic             lit_ok;
  logic             pop_ok;
  logic             push_ok;

  // Occupancy is the pointer distance; the wrap bit keeps full and empty apart.
  assign count   = wr_ptr - rd_ptr;
  assign valid   = (count != '0);
  assign full    = (count == FULL_CNT);
  assign lit_ok  = push && (lit != '0);
  assign pop_ok  = pop && valid;
  assign push_ok = lit_ok && (!full || pop_ok);
  // A flush discards everything in its cycle, so it never counts as a drop.
  assign drop    = lit_ok && full && !pop_ok && !flush;
  assign head    = valid ? mem[rd_ptr[AW-1:0]] : '0;

  // Pointer update: reset and flush both return the queue to empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (rst && !flush && push_ok) mem[wr_ptr[AW-1:0]] <= lit;
  end
endmodule

module eng_ucq_port #(
  parameter int IN_DEPTH  = 8,
  parameter int OUT_DEPTH = 8,
  parameter int LIT_W     = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         bcp_imp_push,
  input  logic [LIT_W-1:0]             bcp_imp_lit,
  output logic [LIT_W-1:0]             eng2uca_min,
  output logic                         eng2uca_valid,
  output logic                         eng2uca_empty,
  input  logic                         uca2eng_pop,
  input  logic                         uca2eng_push,
  input  logic [LIT_W-1:0]             uca2eng_lit,
  output logic                         eng2uca_full,
  output logic [LIT_W-1:0]             bcp_uc_lit,
  output logic                         bcp_uc_valid,
  input  logic                         bcp_uc_pop,
  output logic [$clog2(IN_DEPTH):0]    in_count,
  output logic [$clog2(OUT_DEPTH):0]   out_count,
  output logic                         ovf
);
  logic in_full;
  logic in_drop;
  logic out_drop;

  eng_ucq_fifo #(.DEPTH(IN_DEPTH), .LIT_W(LIT_W)) u_ucq_in (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (bcp_imp_push),
    .lit   (bcp_imp_lit),
    .pop   (uca2eng_pop),
    .head  (eng2uca_min),
    .valid (eng2uca_valid),
    .full  (in_full),
    .count (in_count),
    .drop  (in_drop)
  );

  eng_ucq_fifo #(.DEPTH(OUT_DEPTH), .LIT_W(LIT_W)) u_ucq_out (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (uca2eng_push),
    .lit   (uca2eng_lit),
    .pop   (bcp_uc_pop),
    .head  (bcp_uc_lit),
    .valid (bcp_uc_valid),
    .full  (eng2uca_full),
    .count (out_count),
    .drop  (out_drop)
  );

  assign eng2uca_empty = !eng2uca_valid;

  // Sticky overflow: any dropped push on either queue; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (in_drop || out_drop) begin
      ovf <= 1'b1;
    end
  end

  // UCQ_IN full is only relevant internally (drop detection).
  logic unused_in_full;
  assign unused_in_full = in_full;
endmodule

// File: tb/tb_eng_ucq_port.sv
// Directed bench for eng_ucq_port: stimulus pushes expected literals into
// per-queue scoreboards; a monitor pops and compares whenever a head is consumed.

module tb_eng_ucq_port;
  localparam int W = 32;
  localparam int IN_DEPTH  = 8;
  localparam int OUT_DEPTH = 8;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         bcp_imp_push;
  logic [W-1:0] bcp_imp_lit;
  logic [W-1:0] eng2uca_min;
  logic         eng2uca_valid;
  logic         eng2uca_empty;
  logic         uca2eng_pop;
  logic         uca2eng_push;
  logic [W-1:0] uca2eng_lit;
  logic         eng2uca_full;
  logic [W-1:0] bcp_uc_lit;
  logic         bcp_uc_valid;
  logic         bcp_uc_pop;
  logic [3:0]   in_count;
  logic [3:0]   out_count;
  logic         ovf;

  logic [W-1:0] exp_in_q[$];
  logic [W-1:0] exp_out_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;

  eng_ucq_port #(.IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH), .LIT_W(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .bcp_imp_push  (bcp_imp_push),
    .bcp_imp_lit   (bcp_imp_lit),
    .eng2uca_min   (eng2uca_min),
    .eng2uca_valid (eng2uca_valid),
    .eng2uca_empty (eng2uca_empty),
    .uca2eng_pop   (uca2eng_pop),
    .uca2eng_push  (uca2eng_push),
    .uca2eng_lit   (uca2eng_lit),
    .eng2uca_full  (eng2uca_full),
    .bcp_uc_lit    (bcp_uc_lit),
    .bcp_uc_valid  (bcp_uc_valid),
    .bcp_uc_pop    (bcp_uc_pop),
    .in_count      (in_count),
    .out_count     (out_count),
    .ovf           (ovf)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    bcp_imp_push = 1'b0;
    uca2eng_pop  = 1'b0;
    uca2eng_push = 1'b0;
    bcp_uc_pop   = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic drive_in(input logic push, input logic [W-1:0] lit, input logic pop);
    bcp_imp_push = push;
    bcp_imp_lit  = lit;
    uca2eng_pop  = pop;
    if (push && lit != '0 &&
        (exp_in_q.size() < IN_DEPTH || (pop && exp_in_q.size() > 0)))
      exp_in_q.push_back(lit);
  endtask

  task automatic drive_out(input logic push, input logic [W-1:0] lit, input logic pop);
    uca2eng_push = push;
    uca2eng_lit  = lit;
    bcp_uc_pop   = pop;
    if (push && lit != '0 &&
        (exp_out_q.size() < OUT_DEPTH || (pop && exp_out_q.size() > 0)))
      exp_out_q.push_back(lit);
  endtask

  // Scoreboard monitor: compare each consumed head against the expected queue
  always @(negedge clk) begin
    if (rst && !flush) begin
      if (uca2eng_pop && eng2uca_valid) begin
        if (exp_in_q.size() == 0) begin
          total_cnt++;
          $display("FAIL in_head: got %0h expected nothing", eng2uca_min);
        end else chk("in_head", eng2uca_min, exp_in_q.pop_front());
      end
      if (bcp_uc_pop && bcp_uc_valid) begin
        if (exp_out_q.size() == 0) begin
          total_cnt++;
          $display("FAIL out_head: got %0h expected nothing", bcp_uc_lit);
        end else chk("out_head", bcp_uc_lit, exp_out_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b0; flush = 1'b0;
    bcp_imp_push = 1'b0; bcp_imp_lit = '0; uca2eng_pop = 1'b0;
    uca2eng_push = 1'b0; uca2eng_lit = '0; bcp_uc_pop = 1'b0;

    // 1: reset held 3 cycles with pushes active
    for (int i = 0; i < 3; i++) begin
      bcp_imp_push = 1'b1; bcp_imp_lit = 32'd5;
      uca2eng_push = 1'b1; uca2eng_lit = 32'd9;
      step();
    end
    chk("rst_in_count", 32'(in_count), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_empty", 32'(eng2uca_empty), 32'd1);
    chk("rst_in_valid", 32'(eng2uca_valid), 32'd0);
    chk("rst_out_valid", 32'(bcp_uc_valid), 32'd0);
    chk("rst_full", 32'(eng2uca_full), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_min", eng2uca_min, 32'd0);
    chk("rst_uc_lit", bcp_uc_lit, 32'd0);
    rst = 1'b1;
    step();

    // 2: FIFO order on UCQ_IN
    drive_in(1'b1, 32'd3, 1'b0);  step();
    drive_in(1'b1, -32'sd5, 1'b0); step();
    drive_in(1'b1, 32'd7, 1'b0);  step();
    chk("ord_count3", 32'(in_count), 32'd3);
    chk("ord_head", eng2uca_min, 32'd3);
    chk("ord_empty0", 32'(eng2uca_empty), 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive_in(1'b0, '0, 1'b1); step();
    end
    chk("ord_count0", 32'(in_count), 32'd0);
    chk("ord_empty1", 32'(eng2uca_empty), 32'd1);
    chk("ord_min0", eng2uca_min, 32'd0);

    // 4: literal zero and pop on empty
    drive_in(1'b1, 32'd0, 1'b0); step();
    chk("zero_count", 32'(in_count), 32'd0);
    chk("zero_ovf", 32'(ovf), 32'd0);
    drive_in(1'b0, '0, 1'b1); step();
    chk("pop_empty_count", 32'(in_count), 32'd0);
    chk("pop_empty_empty", 32'(eng2uca_empty), 32'd1);
    chk("pop_empty_ovf", 32'(ovf), 32'd0);

    // 3: fill UCQ_OUT, overflow, push+pop at full
    for (int i = 1; i <= 9; i++) begin
      drive_out(1'b1, 32'(i), 1'b0); step();
      if (i == 7) chk("out_full_7", 32'(eng2uca_full), 32'd0);
      if (i == 8) begin
        chk("out_full_8", 32'(eng2uca_full), 32'd1);
        chk("out_ovf_8", 32'(ovf), 32'd0);
      end
    end
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_count", 32'(out_count), 32'd8);
    drive_out(1'b1, 32'd100, 1'b1); step();
    chk("fullpp_count", 32'(out_count), 32'd8);
    chk("fullpp_full", 32'(eng2uca_full), 32'd1);
    chk("fullpp_head", bcp_uc_lit, 32'd2);
    for (int i = 0; i < 8; i++) begin
      drive_out(1'b0, '0, 1'b1); step();
    end
    chk("drain_count", 32'(out_count), 32'd0);
    chk("drain_full", 32'(eng2uca_full), 32'd0);
    chk("drain_valid", 32'(bcp_uc_valid), 32'd0);
    chk("in_indep_count", 32'(in_count), 32'd0);

    // 5: wrap-around on UCQ_IN at occupancy 1..7
    drive_in(1'b1, 32'd50, 1'b0); step();
    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] l;
      l = (i % 2 == 1) ? -(32'(i) + 32'd20) : 32'(i) + 32'd20;
      if (i < 6)       drive_in(1'b1, l, 1'b0);
      else if (i < 12) drive_in(1'b1, l, 1'b1);
      else if (i < 18) drive_in(1'b0, '0, 1'b1);
      else             drive_in(1'b1, l, 1'b1);
      step();
      chk("wrap_count", 32'(in_count), 32'(exp_in_q.size()));
    end
    drive_in(1'b0, '0, 1'b1); step();
    chk("wrap_drained", 32'(in_count), 32'd0);

    // 6: flush with 5/6 entries and same-cycle push+pop
    for (int i = 0; i < 6; i++) begin
      if (i < 5) drive_in(1'b1, 32'(61 + i), 1'b0);
      drive_out(1'b1, 32'(71 + i), 1'b0);
      step();
    end
    chk("pre_flush_in", 32'(in_count), 32'd5);
    chk("pre_flush_out", 32'(out_count), 32'd6);
    drive_in(1'b1, 32'd66, 1'b1);
    drive_out(1'b1, 32'd77, 1'b1);
    flush = 1'b1;
    exp_in_q.delete();
    exp_out_q.delete();
    step();
    chk("flush_in_count", 32'(in_count), 32'd0);
    chk("flush_out_count", 32'(out_count), 32'd0);
    chk("flush_in_valid", 32'(eng2uca_valid), 32'd0);
    chk("flush_out_valid", 32'(bcp_uc_valid), 32'd0);
    chk("flush_ovf_kept", 32'(ovf), 32'd1);
    drive_in(1'b1, 32'd80, 1'b0);
    drive_out(1'b1, 32'd81, 1'b0);
    step();
    chk("post_flush_in", 32'(in_count), 32'd1);
    drive_in(1'b0, '0, 1'b1);
    drive_out(1'b0, '0, 1'b1);
    step();
    chk("post_flush_empty", 32'(eng2uca_empty), 32'd1);
    chk("sb_in_empty", 32'(exp_in_q.size()), 32'd0);
    chk("sb_out_empty", 32'(exp_out_q.size()), 32'd0);

    // Final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
